// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
// Two independent valid/ready handshakes: one for requests, one for responses.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Initiator side (core or bus master)
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder side (the memory)
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder with a fixed number of wait states.
// One request in flight at a time: IDLE accepts, WAIT burns the latency,
// the access happens on the edge into RESP, RESP holds the result until taken.
// Misaligned or out-of-range addresses are flagged and never touch memory.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    logic                  accept;
    logic                  do_access;
    logic                  access_err;
    logic [ADDR_WIDTH-1:0] word_idx;

    assign accept     = (state_q == IDLE) && bus.req_valid;
    // Counter reaching zero in WAIT marks the edge that performs the access;
    // this gives WAIT_CYCLES+1 edges from acceptance to the response.
    assign do_access  = (state_q == WAIT) && (cnt_q == 4'd0);
    assign access_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
    assign word_idx   = addr_q[ADDR_WIDTH+1:2];

    // Handshake outputs come straight from registered state only
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // Next-state and wait-counter decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, captured request and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
            if (do_access) begin
                err_q   <= access_err;
                rdata_q <= (!write_q && !access_err) ? mem_q[word_idx] : 32'd0;
            end
        end
    end

    // Byte-lane store into the array; contents survive reset, but a store
    // whose commit edge coincides with reset is dropped
    always_ff @(posedge clk) begin
        if (!reset && do_access && write_q && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// Two instances share a clock: one with 2 wait states, one with none.
// A word-array model computes expected data, error flag and latency.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel0;          // 1 = talk to the zero-wait instance
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    dmem_responder_if bif2 ();
    dmem_responder_if bif0 ();

    assign bif2.req_valid = req_valid & ~sel0;
    assign bif0.req_valid = req_valid & sel0;
    assign bif2.rsp_ready = rsp_ready & ~sel0;
    assign bif0.rsp_ready = rsp_ready & sel0;
    assign bif2.req_write = req_write;
    assign bif0.req_write = req_write;
    assign bif2.req_addr  = req_addr;
    assign bif0.req_addr  = req_addr;
    assign bif2.req_wdata = req_wdata;
    assign bif0.req_wdata = req_wdata;
    assign bif2.req_be    = req_be;
    assign bif0.req_be    = req_be;

    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    assign o_req_ready = sel0 ? bif0.req_ready : bif2.req_ready;
    assign o_rsp_valid = sel0 ? bif0.rsp_valid : bif2.rsp_valid;
    assign o_rsp_rdata = sel0 ? bif0.rsp_rdata : bif2.rsp_rdata;
    assign o_rsp_err   = sel0 ? bif0.rsp_err   : bif2.rsp_err;

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(bif2));
    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bif0));

    int total = 0;
    int bad   = 0;
    int ntxn  = 0;

    logic [31:0] mm [2][256];   // model memory per instance

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: 1 KiB word-addressed memory, byte-enabled stores
    task automatic model(input bit s, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output bit e);
        int idx;
        e  = ((a % 4) != 0) || (a >= 32'd1024);
        rd = 32'd0;
        if (!e) begin
            idx = int'(a / 4);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mm[s][idx][8*i +: 8] = wd[8*i +: 8];
            end else begin
                rd = mm[s][idx];
            end
        end
    endtask

    // One full transaction; called and returns just after a falling edge
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input int stall, output logic [31:0] rdat, output time acc_t);
        logic [31:0] erd;
        bit          eer;
        int          k;
        int          wexp;
        wexp = sel0 ? 0 : 2;
        model(sel0, w, a, wd, be, erd, eer);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
        k = 0;
        while (!o_req_ready && k < 40) begin @(negedge clk); k++; end
        chk("req_ready_wait", 32'(o_req_ready), 32'd1);
        @(posedge clk);
        acc_t = $time;
        @(negedge clk);
        // Scramble request inputs after acceptance; they must have no effect
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_be = 4'($urandom);
        k = 0;
        while (!o_rsp_valid && k < 40) begin @(posedge clk); k++; @(negedge clk); end
        chk("latency", 32'(k), 32'(1 + wexp));
        chk("rdata", o_rsp_rdata, erd);
        chk("err", 32'(o_rsp_err), 32'(eer));
        chk("req_ready_busy", 32'(o_req_ready), 32'd0);
        rdat = o_rsp_rdata;
        repeat (stall) begin
            @(negedge clk);
            chk("stall_valid", 32'(o_rsp_valid), 32'd1);
            chk("stall_rdata", o_rsp_rdata, erd);
            chk("stall_err", 32'(o_rsp_err), 32'(eer));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after", 32'(o_rsp_valid), 32'd0);
        chk("req_ready_after", 32'(o_req_ready), 32'd1);
        ntxn++;
        $display("txn %0d inst=W%0d %s addr=%h wdata=%h be=%h rdata=%h err=%0d lat=%0d",
                 ntxn, wexp, w ? "st" : "ld", a, wd, be, rdat, eer, k);
    endtask

    initial begin
        logic [31:0] rd, erd;
        bit          eer;
        time         t0, t1;
        int          k;
        logic [31:0] a;

        reset = 1'b1; sel0 = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        rsp_ready = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", 32'(bif2.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bif2.rsp_valid), 32'd0);
        chk("rst_rdata", bif2.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bif2.rsp_err), 32'd0);
        chk("rst0_req_ready", 32'(bif0.req_ready), 32'd1);
        chk("rst0_rsp_valid", 32'(bif0.rsp_valid), 32'd0);

        // Preload every word through the store path
        for (int i = 0; i < 256; i++) begin
            if (i == 1)      rd = 32'h11223344;
            else if (i == 2) rd = 32'h0;
            else if (i == 3) rd = 32'hDEADBEEF;
            else             rd = $urandom;
            txn(1'b1, 32'(i * 4), rd, 4'hF, 0, rd, t0);
        end

        // Plain load
        txn(1'b0, 32'h0C, 32'd0, 4'h0, 0, rd, t0);
        chk("load_deadbeef", rd, 32'hDEADBEEF);

        // Byte-enable store then load back
        txn(1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, 1, rd, t0);
        txn(1'b0, 32'h04, 32'd0, 4'h0, 0, rd, t0);
        chk("be_merge", rd, 32'h11BB33DD);

        // Misaligned load, out-of-range store, empty byte-enable store
        txn(1'b0, 32'h0E, 32'd0, 4'h0, 0, rd, t0);
        txn(1'b1, 32'h400, 32'h12345678, 4'hF, 0, rd, t0);
        txn(1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 0, rd, t0);

        // Back-pressure with a second request waiting
        model(1'b0, 1'b0, 32'h0C, 32'd0, 4'h0, erd, eer);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0C; req_wdata = 32'd0; req_be = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        k = 0;
        while (!o_rsp_valid && k < 40) begin @(posedge clk); k++; @(negedge clk); end
        chk("bp_latency", 32'(k), 32'd3);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(o_rsp_valid), 32'd1);
            chk("bp_rdata", o_rsp_rdata, erd);
            chk("bp_err", 32'(o_rsp_err), 32'd0);
            chk("bp_req_ready", 32'(o_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_valid_drop", 32'(o_rsp_valid), 32'd0);
        chk("bp_ready_back", 32'(o_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        model(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, erd, eer);
        k = 0;
        while (!o_rsp_valid && k < 40) begin @(posedge clk); k++; @(negedge clk); end
        chk("bp2_latency", 32'(k), 32'd3);
        chk("bp2_rdata", o_rsp_rdata, 32'd0);
        chk("bp2_err", 32'(o_rsp_err), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("txn bp pair: load 0x0C stalled 5 cycles, store 0x10 accepted afterwards");

        // Reset lands on the edge that would have committed a store to mem[2]
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h08; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_req_ready", 32'(o_req_ready), 32'd1);
        chk("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("mid_rst_rdata", o_rsp_rdata, 32'd0);
        chk("mid_rst_err", 32'(o_rsp_err), 32'd0);
        $display("txn reset during WAIT of store 0x08");
        txn(1'b0, 32'h08, 32'd0, 4'h0, 0, rd, t0);
        chk("mid_rst_discard", rd, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int cat;
            cat = int'($urandom_range(0, 9));
            if (cat == 0)      a = ($urandom_range(0, 255) * 4) + $urandom_range(1, 3);
            else if (cat == 1) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
            else               a = $urandom_range(0, 255) * 4;
            txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), rd, t0);
        end

        // Zero-wait instance: seed two words, then back-to-back loads
        sel0 = 1'b1;
        txn(1'b1, 32'h00, 32'h0BADF00D, 4'hF, 0, rd, t0);
        txn(1'b1, 32'h04, 32'h600DCAFE, 4'hF, 0, rd, t0);
        txn(1'b0, 32'h00, 32'd0, 4'h0, 0, rd, t0);
        chk("w0_load0", rd, 32'h0BADF00D);
        txn(1'b0, 32'h04, 32'd0, 4'h0, 0, rd, t1);
        chk("w0_load4", rd, 32'h600DCAFE);
        chk("w0_throughput", 32'((t1 - t0) / 10), 32'd3);
        sel0 = 1'b0;

        // Full sweep of the 2-wait instance against the model
        for (int i = 0; i < 256; i++) begin
            txn(1'b0, 32'(i * 4), 32'd0, 4'h0, 0, rd, t0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
